// File: rtl/mips_pkg.sv
// Shared MIPS definitions: bus widths, the end-of-program marker and the
// instruction loader state encoding.
package mips_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_BYTE = 8;
    localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instruction_loader.sv
// Assembles UART RX bytes (big-endian) into instruction words and writes them
// to consecutive word addresses of the instruction memory, starting at 0.
module instruction_loader #(
    parameter int                   NB_DATA   = mips_pkg::NB_DATA,
    parameter int                   NB_BYTE   = mips_pkg::NB_BYTE,
    parameter int                   NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0]   HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_done,
    output logic                o_mem_wr_en,
    output logic [NB_ADDR-1:0]  o_mem_wr_addr,
    output logic [NB_DATA-1:0]  o_mem_wr_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overflow,
    output logic [NB_ADDR:0]    o_word_count
);
    import mips_pkg::*;

    localparam int                  BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int                  NB_BCNT        = $clog2(BYTES_PER_WORD);
    localparam logic [NB_BCNT-1:0]  LAST_BYTE      = NB_BCNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_ADDR-1:0]  LAST_ADDR      = '1;

    loader_state_e          state_q, state_d;
    logic [NB_BCNT-1:0]     byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0]     shift_q, shift_d;
    logic [NB_ADDR-1:0]     addr_q, addr_d;
    logic [NB_ADDR:0]       count_q, count_d;
    logic [NB_ADDR-1:0]     wr_addr_q, wr_addr_d;
    logic [NB_DATA-1:0]     wr_data_q, wr_data_d;
    logic                   overflow_q, overflow_d;
    logic [NB_DATA-1:0]     shifted;

    assign shifted = {shift_q[NB_DATA-NB_BYTE-1:0], i_rx_data};

    always_comb begin
        // NOTE: every _d takes its _q as a default first, so no branch of the case can infer a latch.
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d    = RECV;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            RECV: begin
                if (i_rx_done) begin
                    shift_d = shifted;
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Address and word are captured here and held until the next write.
                        state_d    = WRITE;
                        byte_cnt_d = '0;
                        wr_addr_d  = addr_q;
                        wr_data_d  = shifted;
                    end else begin
                        byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
                    end
                end
            end
            WRITE: begin
                count_d = count_q + (NB_ADDR+1)'(1);
                if (wr_data_q == HALT_WORD || addr_q == LAST_ADDR) begin
                    state_d    = DONE;
                    overflow_d = (wr_data_q != HALT_WORD);
                end else begin
                    state_d = RECV;
                    addr_d  = addr_q + NB_ADDR'(1);
                    if (i_rx_done) begin
                        shift_d    = shifted;
                        byte_cnt_d = NB_BCNT'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_mem_wr_en   = (state_q == WRITE);
    assign o_mem_wr_addr = wr_addr_q;
    assign o_mem_wr_data = wr_data_q;
    assign o_busy        = (state_q == RECV) || (state_q == WRITE);
    assign o_done        = (state_q == DONE);
    assign o_overflow    = overflow_q;
    assign o_word_count  = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Drives a 256-word and a 4-word loader with the same byte stream and compares
// both, every cycle, against a byte-queue reference model.
module tb_instruction_loader;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, rx_done;
    logic [7:0]  rx_data;

    logic        wr_en_a, busy_a, done_a, ovf_a;
    logic [7:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic [8:0]  count_a;
    logic        wr_en_b, busy_b, done_b, ovf_b;
    logic [1:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_loader #(.NB_ADDR(8)) u_dut_a (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_mem_wr_en(wr_en_a), .o_mem_wr_addr(wr_addr_a), .o_mem_wr_data(wr_data_a),
        .o_busy(busy_a), .o_done(done_a), .o_overflow(ovf_a), .o_word_count(count_a)
    );

    instruction_loader #(.NB_ADDR(2)) u_dut_b (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_mem_wr_en(wr_en_b), .o_mem_wr_addr(wr_addr_b), .o_mem_wr_data(wr_data_b),
        .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b), .o_word_count(count_b)
    );

    // Reference model, one slot per DUT: bytes collect in m_buf until a word is complete.
    int          depth [2] = '{256, 4};
    bit          m_load [2], m_wr [2], m_done [2], m_ovf [2];
    logic [7:0]  m_buf [2][4];
    int          m_nb [2], m_next [2], m_cnt [2], m_waddr [2];
    logic [31:0] m_wdata [2];

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic s, input logic d,
                              input logic [7:0] b);
        if (r) begin
            m_load[i] = 0; m_wr[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
            m_nb[i] = 0; m_next[i] = 0; m_cnt[i] = 0; m_waddr[i] = 0; m_wdata[i] = '0;
        end else if (m_wr[i]) begin
            m_wr[i] = 0;
            m_cnt[i]++;
            if (m_wdata[i] == HALT_WORD || m_waddr[i] == depth[i] - 1) begin
                m_done[i] = 1;
                m_ovf[i]  = (m_wdata[i] != HALT_WORD);
                m_load[i] = 0;
                m_nb[i]   = 0;
            end else begin
                m_next[i] = m_waddr[i] + 1;
                if (d) begin
                    m_buf[i][0] = b;
                    m_nb[i] = 1;
                end
            end
        end else if (m_load[i]) begin
            if (d) begin
                m_buf[i][m_nb[i]] = b;
                m_nb[i]++;
                if (m_nb[i] == 4) begin
                    m_wdata[i] = {m_buf[i][0], m_buf[i][1], m_buf[i][2], m_buf[i][3]};
                    m_waddr[i] = m_next[i];
                    m_wr[i]    = 1;
                    m_nb[i]    = 0;
                end
            end
        end else if (s) begin
            m_load[i] = 1; m_done[i] = 0; m_ovf[i] = 0;
            m_cnt[i] = 0; m_next[i] = 0; m_nb[i] = 0;
        end
    endtask

    task automatic compare_outputs();
        check("a_wr_en",   wr_en_a,   m_wr[0]);
        check("a_wr_addr", wr_addr_a, m_waddr[0]);
        check("a_wr_data", wr_data_a, m_wdata[0]);
        check("a_busy",    busy_a,    m_load[0]);
        check("a_done",    done_a,    m_done[0]);
        check("a_ovf",     ovf_a,     m_ovf[0]);
        check("a_count",   count_a,   m_cnt[0]);
        check("b_wr_en",   wr_en_b,   m_wr[1]);
        check("b_wr_addr", wr_addr_b, m_waddr[1]);
        check("b_wr_data", wr_data_b, m_wdata[1]);
        check("b_busy",    busy_b,    m_load[1]);
        check("b_done",    done_b,    m_done[1]);
        check("b_ovf",     ovf_b,     m_ovf[1]);
        check("b_count",   count_b,   m_cnt[1]);
    endtask

    // Drive one cycle of inputs, advance the model on the same edge, compare 1 time unit later.
    task automatic step(input logic r, input logic s, input logic d, input logic [7:0] b);
        rst = r; start = s; rx_done = d; rx_data = b;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, r, s, d, b);
        #1;
        if (wr_en_a) mem_a[wr_addr_a] = wr_data_a;
        if (wr_en_b) mem_b[wr_addr_b] = wr_data_b;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) begin
            step(1'b0, 1'b0, 1'b1, w[k*8 +: 8]);
            idle(gap);
        end
    endtask

    initial begin
        logic [31:0] seq;
        rst = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = '0;

        // Reset, then bytes in IDLE must not write.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        check("idle_no_write", wr_en_a | wr_en_b, 1'b0);

        // Basic load ending on HALT.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send_word(32'h2010_0004, 1);
        send_word(32'h8C22_0000, 1);
        send_word(32'hFFFF_FFFF, 1);
        idle(3);
        check("basic_w0", mem_a[0], 32'h2010_0004);
        check("basic_w1", mem_a[1], 32'h8C22_0000);
        check("basic_w2", mem_a[2], 32'hFFFF_FFFF);
        check("basic_done", done_a, 1'b1);
        check("basic_count", count_a, 9'd3);
        check("basic_ovf", ovf_a, 1'b0);
        check("basic_b_ovf", ovf_b, 1'b0);

        // Restart from DONE, then back-to-back bytes including the WRITE cycle; start while busy ignored.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("restart_done", done_a, 1'b0);
        check("restart_count", count_a, 9'd0);
        seq = 32'h1122_3344;
        for (int k = 3; k >= 0; k--) step(1'b0, 1'b0, 1'b1, seq[k*8 +: 8]);
        seq = 32'h5566_7788;
        for (int k = 3; k >= 0; k--) step(1'b0, (k == 2), 1'b1, seq[k*8 +: 8]);
        idle(2);
        check("b2b_w0", mem_a[0], 32'h1122_3344);
        check("b2b_w1", mem_a[1], 32'h5566_7788);
        check("b2b_count", count_a, 9'd2);
        check("b2b_busy", busy_a, 1'b1);

        // Overflow on the 4-word instance; extra bytes afterwards are ignored.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send_word(32'h0102_0304, 0);
        send_word(32'h0506_0708, 0);
        send_word(32'h090A_0B0C, 2);
        send_word(32'h0D0E_0F10, 0);
        idle(1);
        send_word(32'hCAFE_F00D, 0);
        idle(2);
        check("ovf_w0", mem_b[0], 32'h0102_0304);
        check("ovf_w3", mem_b[3], 32'h0D0E_0F10);
        check("ovf_done", done_b, 1'b1);
        check("ovf_flag", ovf_b, 1'b1);
        check("ovf_count", count_b, 3'd4);
        check("ovf_a_w4", mem_a[4], 32'hCAFE_F00D);

        // Mid-load reset: reset coincides with a byte, nothing written, then a fresh word at addr 0.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send_word(32'h1234_5678, 0);
        step(1'b0, 1'b0, 1'b1, 8'h9A);
        step(1'b0, 1'b0, 1'b1, 8'hBC);
        step(1'b0, 1'b0, 1'b1, 8'hDE);
        step(1'b1, 1'b0, 1'b1, 8'hF0);
        check("midrst_no_write", wr_en_a, 1'b0);
        check("midrst_busy", busy_a, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send_word(32'hAABB_CCDD, 1);
        idle(1);
        check("midrst_w0", mem_a[0], 32'hAABB_CCDD);

        // Randomized traffic with occasional reset, start pulses and HALT-biased bytes.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
